// File: rtl/timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : timer
//  Purpose  : Memory-mapped 32-bit timer/compare peripheral with a prescaler,
//             sticky match flag and level interrupt. Defining TIMER_CAPTURE_EN
//             adds the cap_in capture input and the CAP register.
//  Revision : 1.0 - initial release
// ============================================================================
module timer #(
    parameter int          PRESC_W     = 16,
    parameter int unsigned RESET_PRESC = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  addr,
    input  logic        ren,
    output logic [31:0] rdata,
    output logic        rd_valid,
    input  logic        wen,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
`ifdef TIMER_CAPTURE_EN
    input  logic        cap_in,
`endif
    output logic        irq
);

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_PRESC  = 3'd1;
    localparam logic [2:0] REG_COUNT  = 3'd2;
    localparam logic [2:0] REG_CMP    = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_CAP    = 3'd5;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = mask[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    logic [2:0]         ctrl_q,  ctrl_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q,  pcnt_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        cmp_q,   cmp_d;
    logic               match_q, match_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rd_valid_q;
    logic               irq_q,   irq_d;

    logic        tick;
    logic        match_evt;
    logic        wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
    logic        status_clr0;
    logic        capt_flag;
    logic [31:0] cap_val;
    logic [31:0] rd_mux;
    logic        unused_addr;

    assign unused_addr = ^addr[1:0];

`ifdef TIMER_CAPTURE_EN
    logic        sync1_q, sync2_q, sync3_q;
    logic [31:0] cap_q, cap_d;
    logic        capt_q, capt_d;
    logic        cap_rise;

    assign cap_rise  = sync2_q & ~sync3_q;
    assign capt_flag = capt_q;
    assign cap_val   = cap_q;

    always_comb begin
        cap_d  = cap_rise ? count_q : cap_q;
        capt_d = capt_q;
        if (wr_status && wmask[0] && wdata[1]) begin
            capt_d = 1'b0;
        end
        if (cap_rise) begin
            capt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            cap_q   <= '0;
            capt_q  <= 1'b0;
        end else begin
            sync1_q <= cap_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            cap_q   <= cap_d;
            capt_q  <= capt_d;
        end
    end
`else
    assign capt_flag = 1'b0;
    assign cap_val   = '0;
`endif

    always_comb begin
        wr_ctrl     = wen && (addr[4:2] == REG_CTRL);
        wr_presc    = wen && (addr[4:2] == REG_PRESC);
        wr_count    = wen && (addr[4:2] == REG_COUNT);
        wr_cmp      = wen && (addr[4:2] == REG_CMP);
        wr_status   = wen && (addr[4:2] == REG_STATUS);
        status_clr0 = wr_status && wmask[0] && wdata[0];

        tick      = ctrl_q[0] && (pcnt_q == presc_q);
        match_evt = tick && (count_q == cmp_q);

        ctrl_d = ctrl_q;
        if (wr_ctrl) begin
            ctrl_d = 3'(merge_bytes({29'b0, ctrl_q}, wdata, wmask));
        end

        presc_d = presc_q;
        if (wr_presc) begin
            presc_d = PRESC_W'(merge_bytes(32'(presc_q), wdata, wmask));
        end

        if (!ctrl_q[0] || wr_presc || tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + 1'b1;
        end

        // A software write to COUNT overrides any tick in the same cycle.
        count_d = count_q;
        if (tick) begin
            count_d = (match_evt && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
        end
        if (wr_count) begin
            count_d = merge_bytes(count_q, wdata, wmask);
        end

        cmp_d = cmp_q;
        if (wr_cmp) begin
            cmp_d = merge_bytes(cmp_q, wdata, wmask);
        end

        match_d = match_q;
        if (status_clr0) begin
            match_d = 1'b0;
        end
        if (match_evt) begin
            match_d = 1'b1;
        end

        irq_d = (match_q | capt_flag) & ctrl_q[2];
    end

    always_comb begin
        rd_mux = '0;
        case (addr[4:2])
            REG_CTRL:   rd_mux = {29'b0, ctrl_q};
            REG_PRESC:  rd_mux = 32'(presc_q);
            REG_COUNT:  rd_mux = count_q;
            REG_CMP:    rd_mux = cmp_q;
            REG_STATUS: rd_mux = {30'b0, capt_flag, match_q};
            REG_CAP:    rd_mux = cap_val;
            default:    rd_mux = '0;
        endcase
        rdata_d = ren ? rd_mux : rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q     <= '0;
            presc_q    <= PRESC_W'(RESET_PRESC);
            pcnt_q     <= '0;
            count_q    <= '0;
            cmp_q      <= '1;
            match_q    <= 1'b0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            presc_q    <= presc_d;
            pcnt_q     <= pcnt_d;
            count_q    <= count_d;
            cmp_q      <= cmp_d;
            match_q    <= match_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= ren;
            irq_q      <= irq_d;
        end
    end

    assign rdata    = rdata_q;
    assign rd_valid = rd_valid_q;
    assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_timer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_timer
//  Purpose  : Scoreboard bench for timer; reads push expected data, a
//             negedge monitor pops and compares on every rd_valid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_timer;

    localparam logic [4:0] A_CTRL   = 5'h00;
    localparam logic [4:0] A_PRESC  = 5'h04;
    localparam logic [4:0] A_COUNT  = 5'h08;
    localparam logic [4:0] A_CMP    = 5'h0C;
    localparam logic [4:0] A_STATUS = 5'h10;
`ifdef TIMER_CAPTURE_EN
    localparam logic [4:0] A_CAP    = 5'h14;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  addr = '0;
    logic        ren = 1'b0;
    logic [31:0] rdata;
    logic        rd_valid;
    logic        wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wmask = '0;
    logic        irq;
`ifdef TIMER_CAPTURE_EN
    logic        cap_in = 1'b0;
`endif

    timer #(.PRESC_W(16), .RESET_PRESC(0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .ren      (ren),
        .rdata    (rdata),
        .rd_valid (rd_valid),
        .wen      (wen),
        .wdata    (wdata),
        .wmask    (wmask),
`ifdef TIMER_CAPTURE_EN
        .cap_in   (cap_in),
`endif
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Every rd_valid must match the oldest outstanding read, in the right cycle.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rd_valid: rdata=%08h at cycle %0d with no read pending", rdata, cyc_cnt);
            end else begin
                mon_e = sb.pop_front();
                if (rdata !== mon_e.exp || cyc_cnt != mon_e.due) begin
                    errors++;
                    $display("FAIL %s: got %08h at cycle %0d, expected %08h at cycle %0d",
                             mon_e.name, rdata, cyc_cnt, mon_e.exp, mon_e.due);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
        addr  = a;
        wdata = d;
        wmask = m;
        wen   = 1'b1;
        cyc();
        wen   = 1'b0;
        wmask = '0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] e, input string n);
        addr = a;
        ren  = 1'b1;
        sb.push_back('{name: n, exp: e, due: cyc_cnt + 1});
        cyc();
        ren  = 1'b0;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %08h, expected %08h", n, act, e);
        end
    endtask

    logic [31:0] rst_exp [8];

    initial begin
        rst_exp = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};

        // Reset values
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd(5'(i * 4), rst_exp[i], $sformatf("rst_reg%0d", i));
        end

        // Prescaler: one COUNT increment every PRESC+1 clocks
        wr(A_PRESC, 32'd3, 4'hF);
        wr(A_COUNT, 32'd0, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        repeat (40) cyc();
        rd(A_COUNT, 32'd10, "presc_cnt0");
        rd(A_COUNT, 32'd10, "presc_cnt1");
        rd(A_COUNT, 32'd10, "presc_cnt2");
        rd(A_COUNT, 32'd10, "presc_cnt3");
        rd(A_COUNT, 32'd11, "presc_cnt4");
        wr(A_CTRL, 32'd0, 4'hF);

        // Compare, autoreload and irq timing
        wr(A_CMP, 32'd5, 4'hF);
        wr(A_PRESC, 32'd0, 4'hF);
        wr(A_COUNT, 32'd0, 4'hF);
        wr(A_CTRL, 32'd7, 4'hF);
        repeat (5) cyc();
        chk("irq_before_match", {31'b0, irq}, 32'd0);
        cyc();
        chk("irq_match_cycle", {31'b0, irq}, 32'd0);
        rd(A_COUNT, 32'd0, "autoreload_count");
        chk("irq_after_match", {31'b0, irq}, 32'd1);
        rd(A_STATUS, 32'd1, "match_set");
        wr(A_CTRL, 32'd6, 4'hF);
        wr(A_STATUS, 32'd1, 4'h1);
        chk("irq_clr_same", {31'b0, irq}, 32'd1);
        cyc();
        chk("irq_clr_next", {31'b0, irq}, 32'd0);
        rd(A_STATUS, 32'd0, "match_cleared");

        // Byte-masked writes
        wr(A_CMP, 32'h1122_3344, 4'hF);
        wr(A_CMP, 32'hAABB_CCDD, 4'b0101);
        rd(A_CMP, 32'h11BB_33DD, "cmp_bytemask");
        wr(A_CMP, 32'hFFFF_FFFF, 4'b0000);
        rd(A_CMP, 32'h11BB_33DD, "cmp_mask0");

        // W1C colliding with a match: set wins
        wr(A_CMP, 32'd3, 4'hF);
        wr(A_COUNT, 32'd0, 4'hF);
        wr(A_CTRL, 32'd3, 4'hF);
        repeat (3) cyc();
        wr(A_STATUS, 32'd1, 4'h1);
        wr(A_CTRL, 32'd0, 4'hF);
        rd(A_STATUS, 32'd1, "w1c_vs_match");
        rd(A_COUNT, 32'd1, "autoreload_then_tick");
        wr(A_STATUS, 32'd1, 4'h1);
        rd(A_STATUS, 32'd0, "w1c_clear");

        // COUNT write in a tick cycle
        wr(A_COUNT, 32'd0, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        wr(A_COUNT, 32'h100, 4'hF);
        rd(A_COUNT, 32'h100, "count_wr_vs_tick");
        wr(A_CTRL, 32'd0, 4'hF);

        // Wrap-around without match, then match on 0
        wr(A_PRESC, 32'd1, 4'hF);
        wr(A_COUNT, 32'hFFFF_FFFF, 4'hF);
        wr(A_CMP, 32'd0, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        cyc();
        cyc();
        rd(A_COUNT, 32'd0, "wrap_count");
        rd(A_STATUS, 32'd0, "wrap_no_match");
        rd(A_STATUS, 32'd1, "match_after_wrap");
        wr(A_CTRL, 32'd0, 4'hF);
        wr(A_STATUS, 32'd1, 4'h1);
        rd(A_STATUS, 32'd0, "wrap_status_clr");

`ifdef TIMER_CAPTURE_EN
        // Capture: synchronizer + edge detect, CAP from the detect cycle
        wr(A_CMP, 32'hFFFF_FFFF, 4'hF);
        wr(A_PRESC, 32'd0, 4'hF);
        wr(A_COUNT, 32'd0, 4'hF);
        wr(A_CTRL, 32'd1, 4'hF);
        cap_in = 1'b1;
        repeat (3) cyc();
        cap_in = 1'b0;
        wr(A_CTRL, 32'd0, 4'hF);
        rd(A_CAP, 32'd2, "cap_first");
        rd(A_STATUS, 32'd2, "capt_set");
        wr(A_CTRL, 32'd1, 4'hF);
        cap_in = 1'b1;
        repeat (3) cyc();
        cap_in = 1'b0;
        wr(A_CTRL, 32'd0, 4'hF);
        rd(A_CAP, 32'd6, "cap_second");
        cap_in = 1'b1;
        repeat (3) cyc();
        rst_n  = 1'b0;
        cap_in = 1'b0;
        cyc();
        cyc();
        rst_n  = 1'b1;
        rd(A_CAP, 32'd0, "cap_after_reset");
        rd(A_STATUS, 32'd0, "capt_after_reset");
`endif

        repeat (3) cyc();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_reads: %0d reads never returned, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
